// File: rtl/pointer_collision.sv
// pointer_collision: per-pixel collision detector between the obstacle pixel
// stream and the mouse-pointer bounding box. Overlap is accumulated over one
// frame and at each frame boundary a life is charged.
// Optional feature macro: POINTER_COLLISION_GRACE_EN adds an invulnerability
// window of GRACE_FRAMES frames after every non-final hit.
module pointer_collision #(
  parameter int CURSOR_W     = 16,
  parameter int CURSOR_H     = 16,
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        game_on,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        hit,
  output logic [3:0]  lives,
  output logic        invulnerable,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, ARMED, GRACE, DEAD} state_t;

  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);
  localparam logic [12:0] BOX_W      = 13'(CURSOR_W - 1);
  localparam logic [12:0] BOX_H      = 13'(CURSOR_H - 1);

  state_t      state_q, state_d;
  logic [11:0] mx_q, mx_d, my_q, my_d;
  logic        frameHit_q, frameHit_d;
  logic        hit_q, hit_d;
  logic [3:0]  lives_q, lives_d;
  logic [11:0] curX, curY;
  logic        pixValid, overlap, charge, lastLife;

`ifdef POINTER_COLLISION_GRACE_EN
  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);
  logic [7:0] graceCnt_q, graceCnt_d;
`else
  logic unusedGrace;
  assign unusedGrace = |8'(GRACE_FRAMES);
`endif

  // Pixel-vs-box test; the frame_start pixel uses the live pointer position
  always_comb begin
    curX     = frame_start ? mouse_xpos : mx_q;
    curY     = frame_start ? mouse_ypos : my_q;
    pixValid = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
    overlap  = pixValid &&
               ({1'b0, obstacle_x} >= {1'b0, curX}) &&
               ({1'b0, obstacle_x} <= ({1'b0, curX} + BOX_W)) &&
               ({1'b0, obstacle_y} >= {1'b0, curY}) &&
               ({1'b0, obstacle_y} <= ({1'b0, curY} + BOX_H));
    charge   = game_on && frame_start && frameHit_q && (state_q == ARMED);
    lastLife = (lives_q <= 4'd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping game_on always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!game_on) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (frame_start) state_d = ARMED;
        ARMED: begin
          if (charge) begin
`ifdef POINTER_COLLISION_GRACE_EN
            state_d = lastLife ? DEAD : GRACE;
`else
            state_d = lastLife ? DEAD : ARMED;
`endif
          end
        end
`ifdef POINTER_COLLISION_GRACE_EN
        GRACE: if (frame_start && (graceCnt_q <= 8'd1)) state_d = ARMED;
`else
        GRACE: state_d = ARMED;
`endif
        DEAD:    state_d = DEAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: pointer latch, frame flag, lives, hit and grace counter
  always_comb begin
    mx_d       = frame_start ? mouse_xpos : mx_q;
    my_d       = frame_start ? mouse_ypos : my_q;
    frameHit_d = frameHit_q | overlap;
    hit_d      = charge;
    lives_d    = lives_q;
    if (!game_on) begin
      frameHit_d = 1'b0;
    end else if (frame_start) begin
      frameHit_d = overlap;
    end else if (state_q == IDLE) begin
      frameHit_d = 1'b0;
    end
    if (!game_on || (state_q == IDLE)) begin
      lives_d = LIVES_INIT;
    end else if (charge && (lives_q != 4'd0)) begin
      lives_d = lives_q - 4'd1;
    end
`ifdef POINTER_COLLISION_GRACE_EN
    graceCnt_d = graceCnt_q;
    if (!game_on) begin
      graceCnt_d = 8'd0;
    end else if (charge && !lastLife) begin
      graceCnt_d = GRACE_INIT;
    end else if ((state_q == GRACE) && frame_start && (graceCnt_q != 8'd0)) begin
      graceCnt_d = graceCnt_q - 8'd1;
    end
`endif
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mx_q       <= 12'd0;
      my_q       <= 12'd0;
      frameHit_q <= 1'b0;
      hit_q      <= 1'b0;
      lives_q    <= LIVES_INIT;
`ifdef POINTER_COLLISION_GRACE_EN
      graceCnt_q <= 8'd0;
`endif
    end else begin
      mx_q       <= mx_d;
      my_q       <= my_d;
      frameHit_q <= frameHit_d;
      hit_q      <= hit_d;
      lives_q    <= lives_d;
`ifdef POINTER_COLLISION_GRACE_EN
      graceCnt_q <= graceCnt_d;
`endif
    end
  end

  // Output decode from the registered state
  always_comb begin
    hit       = hit_q;
    lives     = lives_q;
    game_over = (state_q == DEAD);
`ifdef POINTER_COLLISION_GRACE_EN
    invulnerable = (state_q == GRACE);
`else
    invulnerable = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pointer_collision.sv
// tb_pointer_collision: directed self-checking bench for pointer_collision.
// Expectations depend on whether POINTER_COLLISION_GRACE_EN is defined.
module tb_pointer_collision;

  localparam int FRAME_LEN = 16;
`ifdef POINTER_COLLISION_GRACE_EN
  localparam int EXP_INV = 1;
  localparam int EXP_H2  = 62;
  localparam int EXP_H3  = 123;
`else
  localparam int EXP_INV = 0;
  localparam int EXP_H2  = 2;
  localparam int EXP_H3  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        game_on = 1'b0;
  logic [11:0] obstacle_x = 12'd0;
  logic [11:0] obstacle_y = 12'd0;
  logic [11:0] mouse_xpos = 12'd0;
  logic [11:0] mouse_ypos = 12'd0;
  logic        hit;
  logic [3:0]  lives;
  logic        invulnerable;
  logic        game_over;

  int assertCount = 0;
  int failCount   = 0;
  int hitCount    = 0;

  pointer_collision dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .game_on      (game_on),
    .obstacle_x   (obstacle_x),
    .obstacle_y   (obstacle_y),
    .mouse_xpos   (mouse_xpos),
    .mouse_ypos   (mouse_ypos),
    .hit          (hit),
    .lives        (lives),
    .invulnerable (invulnerable),
    .game_over    (game_over)
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  // Count every cycle in which hit is high, sampled away from the active edge
  always @(negedge clk) begin
    if (hit === 1'b1) hitCount++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic [11:0] ox, input logic [11:0] oy);
    frame_start = fs;
    obstacle_x  = ox;
    obstacle_y  = oy;
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input logic [11:0] ox, input logic [11:0] oy, input int pixCycle,
                          input int rstCycle, output int hits);
    int h0;
    h0 = hitCount;
    for (int c = 0; c < FRAME_LEN; c++) begin
      rst_n = (c == rstCycle) ? 1'b0 : 1'b1;
      if (c == pixCycle) applyStimulus(c == 0, ox, oy);
      else               applyStimulus(c == 0, 12'd0, 12'd0);
    end
    rst_n = 1'b1;
    #2;
    hits = hitCount - h0;
  endtask

  task automatic restartGame(input logic [11:0] mx, input logic [11:0] my);
    int h;
    game_on = 1'b0;
    applyStimulus(1'b0, 12'd0, 12'd0);
    mouse_xpos = mx;
    mouse_ypos = my;
    game_on    = 1'b1;
    runFrame(12'd0, 12'd0, -1, -1, h);
  endtask

  task automatic scenarioHit(input string tag, input logic [11:0] mx, input logic [11:0] my,
                             input logic [11:0] ox, input logic [11:0] oy, input int expHits);
    int h;
    restartGame(mx, my);
    runFrame(ox, oy, 5, -1, h);
    runFrame(12'd0, 12'd0, -1, -1, h);
    checkOutput(tag, h, expHits);
  endtask

  int h;
  int nHits;
  int hitFrames[8];

  initial begin
    // Reset held with stimulus active
    game_on    = 1'b1;
    mouse_xpos = 12'd400;
    mouse_ypos = 12'd300;
    rst_n      = 1'b0;
    applyStimulus(1'b1, 12'd410, 12'd310);
    applyStimulus(1'b0, 12'd410, 12'd310);
    applyStimulus(1'b1, 12'd410, 12'd310);
    checkOutput("rstHit", hit, 0);
    checkOutput("rstLives", lives, 3);
    checkOutput("rstGameOver", game_over, 0);
    checkOutput("rstInv", invulnerable, 0);
    checkOutput("rstHitCount", hitCount, 0);
    rst_n = 1'b1;

    // Single hit: arm, pixel mid-frame, charged after the next frame_start
    runFrame(12'd0, 12'd0, -1, -1, h);
    runFrame(12'd410, 12'd310, 5, -1, h);
    checkOutput("noEarlyHit", h, 0);
    applyStimulus(1'b1, 12'd0, 12'd0);
    checkOutput("singleHit", hit, 1);
    checkOutput("singleLives", lives, 2);
    checkOutput("singleInv", invulnerable, EXP_INV);
    applyStimulus(1'b0, 12'd0, 12'd0);
    checkOutput("hitWidth", hit, 0);

    // Abort mid-grace
    game_on = 1'b0;
    applyStimulus(1'b0, 12'd0, 12'd0);
    checkOutput("abortLives", lives, 3);
    checkOutput("abortInv", invulnerable, 0);
    checkOutput("abortGameOver", game_over, 0);

    // Box edges and invalid pixel
    scenarioHit("edgeIn", 12'd400, 12'd300, 12'd415, 12'd315, 1);
    scenarioHit("edgeRight", 12'd400, 12'd300, 12'd416, 12'd300, 0);
    scenarioHit("edgeLeft", 12'd400, 12'd300, 12'd399, 12'd300, 0);
    scenarioHit("edgeTop", 12'd400, 12'd300, 12'd400, 12'd299, 0);
    scenarioHit("edgeBottom", 12'd400, 12'd300, 12'd400, 12'd316, 0);
    scenarioHit("originInvalid", 12'd0, 12'd0, 12'd0, 12'd0, 0);
    scenarioHit("originValid", 12'd0, 12'd0, 12'd0, 12'd5, 1);
    scenarioHit("nearMax", 12'd4090, 12'd4090, 12'd4095, 12'd4095, 1);
    scenarioHit("nearMaxNoWrap", 12'd4095, 12'd4095, 12'd10, 12'd4095, 0);

    // Pixel on the frame_start cycle belongs to the new frame, uses live pointer
    restartGame(12'd1000, 12'd1000);
    mouse_xpos = 12'd400;
    mouse_ypos = 12'd300;
    runFrame(12'd410, 12'd310, 0, -1, h);
    checkOutput("boundaryNotNow", h, 0);
    runFrame(12'd0, 12'd0, -1, -1, h);
    checkOutput("boundaryNext", h, 1);

    // game_on falling together with frame_start wins over the charge
    restartGame(12'd400, 12'd300);
    runFrame(12'd410, 12'd310, 5, -1, h);
    game_on = 1'b0;
    applyStimulus(1'b1, 12'd0, 12'd0);
    checkOutput("abortFsHit", hit, 0);
    checkOutput("abortFsLives", lives, 3);

    // Reset pulse mid-frame with the flag set drops the pending hit
    restartGame(12'd400, 12'd300);
    runFrame(12'd410, 12'd310, 5, 10, h);
    runFrame(12'd0, 12'd0, -1, -1, h);
    checkOutput("rstPulseHit1", h, 0);
    runFrame(12'd0, 12'd0, -1, -1, h);
    checkOutput("rstPulseHit2", h, 0);
    checkOutput("rstPulseLives", lives, 3);

    // Overlap every frame until the game ends
    game_on = 1'b0;
    applyStimulus(1'b0, 12'd0, 12'd0);
    game_on = 1'b1;
    nHits = 0;
    for (int f = 0; f < 131; f++) begin
      runFrame(12'd410, 12'd310, 5, -1, h);
      if (h != 0 && nHits < 8) begin
        hitFrames[nHits] = f;
        nHits++;
      end
      if (f == 60) checkOutput("invLate", invulnerable, EXP_INV);
      if (f == 61) checkOutput("invDrop", invulnerable, 0);
    end
    checkOutput("totalHits", nHits, 3);
    checkOutput("hit1Frame", hitFrames[0], 1);
    checkOutput("hit2Frame", hitFrames[1], EXP_H2);
    checkOutput("hit3Frame", hitFrames[2], EXP_H3);
    checkOutput("deadLives", lives, 0);
    checkOutput("deadGameOver", game_over, 1);
    checkOutput("deadInv", invulnerable, 0);

    // Leaving the game clears game_over and reloads lives
    game_on = 1'b0;
    applyStimulus(1'b0, 12'd0, 12'd0);
    checkOutput("exitGameOver", game_over, 0);
    checkOutput("exitLives", lives, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
